// File: rtl/ws_power_sequencer.sv
// ---------------------------------------------------------------------------
// ws_power_sequencer
//
// Sequences console power and reset and gates HDMI video output on the
// WonderSwan HDMI path. The console supply is only re-enabled after the full
// discharge wait. The console reset is held for the power-up time after the
// supply is enabled. Video enable is raised only on a frame boundary.
//
// Build option:
//   AUTO_POWER_ON_EN  When defined, PLL lock goes straight to WAIT, and
//                     SHUTDOWN returns to WAIT. The console then boots and
//                     restarts without a button press.
//                     When undefined, both of those go to OFF, and power-on
//                     needs a button press.
//
// Ports:
//   clk            pixel clock
//   rst_n          asynchronous active-low reset
//   pll_lock       PLL lock (asynchronous, synchronized internally)
//   btn_power      raw power button, active-high (asynchronous)
//   frame_start    one-cycle pulse at the first pixel of each frame
//   pwr_en         console supply enable
//   console_rst_n  console reset, active-low
//   video_en       HDMI pixel/audio output enable
//   seq_state      current sequencer state encoding (debug/OSD)
// ---------------------------------------------------------------------------
module ws_power_sequencer #(
    parameter int unsigned POWERUPCYCLES   = 2700000,
    parameter int unsigned POWERWAITCYCLES = 13500000,
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned SHUTDOWN_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       btn_power,
    input  logic       frame_start,
    output logic       pwr_en,
    output logic       console_rst_n,
    output logic       video_en,
    output logic [2:0] seq_state
);

    // A zero-length dwell is promoted to one cycle.
    localparam int unsigned PU_EFF = (POWERUPCYCLES   == 0) ? 1 : POWERUPCYCLES;
    localparam int unsigned PW_EFF = (POWERWAITCYCLES == 0) ? 1 : POWERWAITCYCLES;
    localparam int unsigned DB_EFF = (DEBOUNCE_CYCLES == 0) ? 1 : DEBOUNCE_CYCLES;
    localparam int unsigned SD_EFF = (SHUTDOWN_CYCLES == 0) ? 1 : SHUTDOWN_CYCLES;

    localparam int unsigned MAX_A  = (PU_EFF > PW_EFF) ? PU_EFF : PW_EFF;
    localparam int unsigned MAX_B  = (MAX_A  > DB_EFF) ? MAX_A  : DB_EFF;
    localparam int unsigned MAX_C  = (MAX_B  > SD_EFF) ? MAX_B  : SD_EFF;
    localparam int unsigned CW     = $clog2(MAX_C) + 1;
    localparam int unsigned DW     = $clog2(DB_EFF) + 1;

    localparam logic [CW-1:0] PU_LAST = CW'(PU_EFF - 1);
    localparam logic [CW-1:0] PW_LAST = CW'(PW_EFF - 1);
    localparam logic [CW-1:0] SD_LAST = CW'(SD_EFF - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_OFF      = 3'd1,
        S_WAIT     = 3'd2,
        S_POWERUP  = 3'd3,
        S_RUN      = 3'd4,
        S_SHUTDOWN = 3'd5
    } state_e;

`ifdef AUTO_POWER_ON_EN
    localparam state_e LOCK_NEXT     = S_WAIT;
    localparam state_e SHUTDOWN_NEXT = S_WAIT;
`else
    localparam state_e LOCK_NEXT     = S_OFF;
    localparam state_e SHUTDOWN_NEXT = S_OFF;
`endif

    // -----------------------------------------------------------------------
    // Two-flop synchronizers
    // -----------------------------------------------------------------------
    logic pll_s1_q, pll_s2_q;
    logic btn_s1_q, btn_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_s1_q <= 1'b0;
            pll_s2_q <= 1'b0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
        end else begin
            pll_s1_q <= pll_lock;
            pll_s2_q <= pll_s1_q;
            btn_s1_q <= btn_power;
            btn_s2_q <= btn_s1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Button debounce. The level follows the synchronized button only after
    // the two have disagreed for DB_EFF consecutive cycles. Any agreement
    // restarts the count. press is registered at the same edge the level
    // rises.
    // -----------------------------------------------------------------------
    logic          db_level_q, db_level_d;
    logic [DW-1:0] db_cnt_q,   db_cnt_d;
    logic          press_q,    press_d;

    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        press_d    = 1'b0;
        if (btn_s2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = btn_s2_q;
                press_d    = btn_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
        end else begin
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer FSM. The outputs are registered together with the state, so
    // they always match the state being entered. The dwell counter is
    // cleared on every state entry.
    // -----------------------------------------------------------------------
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          pwr_en_q;
    logic          con_rst_n_q;
    logic          video_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pwr_en_q    <= 1'b0;
            con_rst_n_q <= 1'b0;
            video_en_q  <= 1'b0;
        end else if (state_q != S_IDLE && !pll_s2_q) begin
            // Loss of lock overrides press and counter expiry.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pwr_en_q    <= 1'b0;
            con_rst_n_q <= 1'b0;
            video_en_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pwr_en_q    <= 1'b0;
                    con_rst_n_q <= 1'b0;
                    video_en_q  <= 1'b0;
                    if (pll_s2_q) begin
                        state_q <= LOCK_NEXT;
                        cnt_q   <= '0;
                    end
                end
                S_OFF: begin
                    pwr_en_q    <= 1'b0;
                    con_rst_n_q <= 1'b0;
                    video_en_q  <= 1'b0;
                    if (press_q) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT: begin
                    // press is ignored; the discharge wait always completes.
                    con_rst_n_q <= 1'b0;
                    video_en_q  <= 1'b0;
                    if (cnt_q == PW_LAST) begin
                        state_q  <= S_POWERUP;
                        cnt_q    <= '0;
                        pwr_en_q <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_q + 1'b1;
                        pwr_en_q <= 1'b0;
                    end
                end
                S_POWERUP: begin
                    pwr_en_q   <= 1'b1;
                    video_en_q <= 1'b0;
                    if (press_q) begin
                        // Abort wins over a coincident expiry.
                        state_q     <= S_SHUTDOWN;
                        cnt_q       <= '0;
                        con_rst_n_q <= 1'b0;
                    end else if (cnt_q == PU_LAST) begin
                        state_q     <= S_RUN;
                        cnt_q       <= '0;
                        con_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
                        con_rst_n_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    pwr_en_q <= 1'b1;
                    if (press_q) begin
                        // video_en is left as is here; it clears one cycle
                        // into SHUTDOWN.
                        state_q     <= S_SHUTDOWN;
                        cnt_q       <= '0;
                        con_rst_n_q <= 1'b0;
                    end else begin
                        con_rst_n_q <= 1'b1;
                        if (frame_start) begin
                            video_en_q <= 1'b1;
                        end
                    end
                end
                S_SHUTDOWN: begin
                    video_en_q  <= 1'b0;
                    con_rst_n_q <= 1'b0;
                    if (cnt_q == SD_LAST) begin
                        state_q  <= SHUTDOWN_NEXT;
                        cnt_q    <= '0;
                        pwr_en_q <= 1'b0;
                    end else begin
                        cnt_q    <= cnt_q + 1'b1;
                        pwr_en_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= '0;
                    pwr_en_q    <= 1'b0;
                    con_rst_n_q <= 1'b0;
                    video_en_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pwr_en        = pwr_en_q;
    assign console_rst_n = con_rst_n_q;
    assign video_en      = video_en_q;
    assign seq_state     = state_q;

endmodule

// File: tb/tb_ws_power_sequencer.sv
module tb_ws_power_sequencer;

    localparam int unsigned PU = 20;
    localparam int unsigned PW = 50;
    localparam int unsigned DB = 8;
    localparam int unsigned SD = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_OFF  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_PU   = 3'd3;
    localparam logic [2:0] ST_RUN  = 3'd4;
    localparam logic [2:0] ST_SD   = 3'd5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       btn_power;
    logic       frame_start;
    logic       pwr_en;
    logic       console_rst_n;
    logic       video_en;
    logic [2:0] seq_state;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0] v;
        int         at;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws_power_sequencer #(
        .POWERUPCYCLES  (PU),
        .POWERWAITCYCLES(PW),
        .DEBOUNCE_CYCLES(DB),
        .SHUTDOWN_CYCLES(SD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock     (pll_lock),
        .btn_power    (btn_power),
        .frame_start  (frame_start),
        .pwr_en       (pwr_en),
        .console_rst_n(console_rst_n),
        .video_en     (video_en),
        .seq_state    (seq_state)
    );

    // Advance to just after the given clock edge.
    task automatic go(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected output change {state, pwr_en, console_rst_n, video_en} at a cycle.
    task automatic push(input logic [2:0] st, input logic p, input logic r,
                        input logic v, input int at);
        exp_t e;
        e.v  = {st, p, r, v};
        e.at = at;
        sbq.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [5:0] want);
        logic [5:0] got;
        got = {seq_state, pwr_en, console_rst_n, video_en};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    // Monitor: every change of the observed outputs must match the next queued
    // expectation, both in value and in cycle.
    logic [5:0] prev_v = '0;
    always @(negedge clk) begin
        logic [5:0] cur;
        exp_t       e;
        cur = {seq_state, pwr_en, console_rst_n, video_en};
        if (cur !== prev_v) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: got %b at cycle %0d, required no change",
                         cur, cyc);
            end else begin
                e = sbq.pop_front();
                if (cur !== e.v || cyc != e.at) begin
                    bad++;
                    $display("FAIL transition: got %b at cycle %0d, required %b at cycle %0d",
                             cur, cyc, e.v, e.at);
                end
            end
            prev_v = cur;
        end
    end

    initial begin
        int c;
        int c2;
        int c3;
        int p;

        rst_n       = 1'b1;
        pll_lock    = 1'b0;
        btn_power   = 1'b0;
        frame_start = 1'b0;
        #1 rst_n    = 1'b0;

        // Reset state
        go(3);
        check_now("reset_state", {ST_IDLE, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;

        // Cold boot: lock at cycle 10 -> OFF at 13
        go(10);
        push(ST_OFF, 1'b0, 1'b0, 1'b0, 13);
        pll_lock = 1'b1;

        // Bounce rejection in OFF
        go(20);
        for (int i = 0; i < 20; i++) begin
            btn_power = (i % 2 == 0);
            go(cyc + 5);
        end
        btn_power = 1'b0;
        go(130);
        check_now("bounce_stays_off", {ST_OFF, 1'b0, 1'b0, 1'b0});

        // Press: WAIT +11, POWERUP +50, RUN +20, video on the RUN-entry frame pulse
        c = cyc;
        push(ST_WAIT, 1'b0, 1'b0, 1'b0, c + 11);
        push(ST_PU,   1'b1, 1'b0, 1'b0, c + 61);
        push(ST_RUN,  1'b1, 1'b1, 1'b0, c + 81);
        push(ST_RUN,  1'b1, 1'b1, 1'b1, c + 82);
        btn_power = 1'b1;
        go(c + 20);
        btn_power = 1'b0;
        go(c + 81);
        frame_start = 1'b1;
        go(c + 82);
        frame_start = 1'b0;

        // Shutdown from RUN, then an immediate second press
        go(c + 100);
        c = cyc;
        push(ST_SD,  1'b1, 1'b0, 1'b1, c + 11);
        push(ST_SD,  1'b1, 1'b0, 1'b0, c + 12);
        push(ST_OFF, 1'b0, 1'b0, 1'b0, c + 15);
        btn_power = 1'b1;
        go(c + 20);
        btn_power = 1'b0;
        c2 = c + 32;
        go(c2);
        push(ST_WAIT, 1'b0, 1'b0, 1'b0, c2 + 11);
        push(ST_PU,   1'b1, 1'b0, 1'b0, c2 + 61);
        push(ST_RUN,  1'b1, 1'b1, 1'b0, c2 + 81);
        push(ST_RUN,  1'b1, 1'b1, 1'b1, c2 + 92);
        btn_power = 1'b1;
        go(c2 + 12);
        btn_power = 1'b0;
        // No video until a frame boundary arrives ten cycles into RUN
        go(c2 + 91);
        frame_start = 1'b1;
        go(c2 + 92);
        frame_start = 1'b0;

        // Abort: press arriving while the POWERUP counter reads PU-1
        go(c2 + 110);
        c = cyc;
        push(ST_SD,  1'b1, 1'b0, 1'b1, c + 11);
        push(ST_SD,  1'b1, 1'b0, 1'b0, c + 12);
        push(ST_OFF, 1'b0, 1'b0, 1'b0, c + 15);
        btn_power = 1'b1;
        go(c + 12);
        btn_power = 1'b0;
        c3 = c + 30;
        go(c3);
        p = c3 + 61;
        push(ST_WAIT, 1'b0, 1'b0, 1'b0, c3 + 11);
        push(ST_PU,   1'b1, 1'b0, 1'b0, p);
        push(ST_SD,   1'b1, 1'b0, 1'b0, p + 20);
        push(ST_OFF,  1'b0, 1'b0, 1'b0, p + 24);
        btn_power = 1'b1;
        go(c3 + 12);
        btn_power = 1'b0;
        go(p + 9);
        btn_power = 1'b1;
        go(p + 21);
        btn_power = 1'b0;

        // PLL loss with the POWERUP counter at 10, then relock -> OFF only
        go(p + 45);
        c = cyc;
        push(ST_WAIT, 1'b0, 1'b0, 1'b0, c + 11);
        push(ST_PU,   1'b1, 1'b0, 1'b0, c + 61);
        push(ST_IDLE, 1'b0, 1'b0, 1'b0, c + 74);
        push(ST_OFF,  1'b0, 1'b0, 1'b0, c + 83);
        btn_power = 1'b1;
        go(c + 12);
        btn_power = 1'b0;
        go(c + 71);
        pll_lock = 1'b0;
        go(c + 80);
        pll_lock = 1'b1;
        go(c + 130);
        check_now("relock_no_powerup", {ST_OFF, 1'b0, 1'b0, 1'b0});

        // Asynchronous reset during WAIT
        c = cyc;
        push(ST_WAIT, 1'b0, 1'b0, 1'b0, c + 11);
        push(ST_IDLE, 1'b0, 1'b0, 1'b0, c + 20);
        push(ST_OFF,  1'b0, 1'b0, 1'b0, c + 25);
        btn_power = 1'b1;
        go(c + 12);
        btn_power = 1'b0;
        go(c + 20);
        rst_n = 1'b0;
        #2;
        check_now("async_reset", {ST_IDLE, 1'b0, 1'b0, 1'b0});
        go(c + 22);
        rst_n = 1'b1;
        go(c + 45);
        check_now("post_reset_off", {ST_OFF, 1'b0, 1'b0, 1'b0});

        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL pending_expectations: got %0d left, required 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
